// File: rtl/queen_solver_if.sv
// Handshake and result bundle between the 8-queens search engine and its consumer.
interface queen_solver_if #(
    parameter int unsigned CNT_W = 7
);
    logic             start;
    logic             next;
    logic             busy;
    logic             valid;
    logic             done;
    logic [23:0]      board;
    logic [CNT_W-1:0] count;

    // Consumer side: requests searches and acknowledges solutions.
    modport master (
        output start,
        output next,
        input  busy,
        input  valid,
        input  done,
        input  board,
        input  count
    );

    // Solver side.
    modport slave (
        input  start,
        input  next,
        output busy,
        output valid,
        output done,
        output board,
        output count
    );
endinterface

// File: rtl/queen_solver.sv
// Iterative backtracking 8-queens solver. It tests one candidate or takes one
// backtrack step per cycle, and presents each solution in lexicographic order
// until the consumer acknowledges it.
module queen_solver #(
    parameter int unsigned CNT_W = 7
) (
    input  logic          clk,
    input  logic          reset,
    queen_solver_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        TRY,
        BACK,
        SOLUTION,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [2:0]       cand_q, cand_d;
    logic [2:0]       col_q [8];
    logic [2:0]       col_d [8];
    logic [CNT_W-1:0] count_q, count_d;

    logic [2:0]       dist_w [8];
    logic [7:0]       conflict_w;
    logic             safe_w;
    logic [23:0]      board_w;

    // Safety of (row_q, cand_q) against every queen already placed in rows above it.
    always_comb begin
        conflict_w = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            dist_w[k] = (col_q[k] >= cand_q) ? (col_q[k] - cand_q) : (cand_q - col_q[k]);
            conflict_w[k] = (3'(k) < row_q) &&
                            ((col_q[k] == cand_q) || (dist_w[k] == (row_q - 3'(k))));
        end
        safe_w = ~|conflict_w;
    end

    // Next-state logic: one candidate test or one backtrack step per cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cand_d  = cand_q;
        col_d   = col_q;
        count_d = count_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    col_d   = '{default: '0};
                    row_d   = '0;
                    cand_d  = '0;
                    count_d = '0;
                    state_d = TRY;
                end
            end
            TRY: begin
                if (safe_w) begin
                    col_d[row_q] = cand_q;
                    if (row_q == 3'd7) begin
                        count_d = count_q + CNT_W'(1);
                        state_d = SOLUTION;
                    end else begin
                        row_d  = row_q + 3'd1;
                        cand_d = '0;
                    end
                end else if (cand_q != 3'd7) begin
                    cand_d = cand_q + 3'd1;
                end else if (row_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q - 3'd1;
                    state_d = BACK;
                end
            end
            BACK: begin
                if (col_q[row_q] != 3'd7) begin
                    cand_d  = col_q[row_q] + 3'd1;
                    state_d = TRY;
                end else if (row_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q - 3'd1;
                end
            end
            SOLUTION: begin
                // Resuming from row 7 via BACK continues after the presented placement.
                if (bus.next) begin
                    state_d = BACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            cand_q  <= '0;
            col_q   <= '{default: '0};
            count_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cand_q  <= cand_d;
            col_q   <= col_d;
            count_q <= count_d;
        end
    end

    // Board output packed straight from the column registers.
    always_comb begin
        board_w = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            board_w[3*r +: 3] = col_q[r];
        end
    end

    assign bus.board = board_w;
    assign bus.count = count_q;
    assign bus.busy  = (state_q == TRY) || (state_q == BACK);
    assign bus.valid = (state_q == SOLUTION);
    assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_queen_solver.sv
// Bench for queen_solver: a software search builds the 92 solutions, the
// expected sequence is queued at each start and popped on every valid board.
module tb_queen_solver;

    localparam int unsigned CNT_W      = 7;
    localparam int unsigned WAIT_LIMIT = 6000;

    typedef struct {
        logic [23:0] board;
        int unsigned count;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    queen_solver_if #(.CNT_W(CNT_W)) bus ();

    queen_solver #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_valid  = 0;
    logic [23:0] model_sols [$];
    exp_t        sb_q [$];
    int          mcol [8];
    logic [23:0] last_board;
    logic [23:0] first_board;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit model_safe(input int r, input int c);
        for (int k = 0; k < r; k++) begin
            int d;
            d = mcol[k] - c;
            if (d < 0) d = -d;
            if (mcol[k] == c || d == r - k) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [23:0] pack_model();
        logic [23:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[3*i +: 3] = 3'(mcol[i]);
        return b;
    endfunction

    // Depth-first enumeration, rows top-down and columns ascending.
    task automatic build_model();
        int r;
        r = 0;
        mcol[0] = 0;
        while (r >= 0) begin
            if (mcol[r] > 7) begin
                r--;
                if (r >= 0) mcol[r]++;
            end else if (model_safe(r, mcol[r])) begin
                if (r == 7) begin
                    model_sols.push_back(pack_model());
                    mcol[r]++;
                end else begin
                    r++;
                    mcol[r] = 0;
                end
            end else begin
                mcol[r]++;
            end
        end
    endtask

    function automatic int unsigned conflicts(input logic [23:0] b);
        int unsigned n;
        int ci, cj, d;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                ci = int'(b[3*i +: 3]);
                cj = int'(b[3*j +: 3]);
                d  = ci - cj;
                if (d < 0) d = -d;
                if (ci == cj || d == j - i) n++;
            end
        end
        return n;
    endfunction

    function automatic logic [23:0] pack_cols(input int c0, c1, c2, c3, c4, c5, c6, c7);
        int cs [8];
        logic [23:0] b;
        cs = '{c0, c1, c2, c3, c4, c5, c6, c7};
        b = '0;
        for (int i = 0; i < 8; i++) b[3*i +: 3] = 3'(cs[i]);
        return b;
    endfunction

    task automatic sb_push(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            exp_t e;
            e.board = model_sols[i];
            e.count = i + 1;
            sb_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_event(output bit got_valid, output bit got_done, input bit poke_start);
        got_valid = 1'b0;
        got_done  = 1'b0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            if (bus.valid) begin
                got_valid = 1'b1;
                break;
            end
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            bus.start = poke_start && (i % 97 == 50);
            tick();
        end
        bus.start = 1'b0;
        check("wait_bound", 32'(got_valid | got_done), 32'd1);
    endtask

    task automatic handle_solution(input int hold_cycles, input bit start_with_next);
        exp_t        e;
        logic [23:0] hb;
        logic [31:0] hc;
        int unsigned unstable;
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sol_board", 32'(bus.board), 32'(e.board));
            check("sol_count", 32'(bus.count), e.count);
        end
        check("sol_legal", conflicts(bus.board), 32'd0);
        if (n_valid == 0) first_board = bus.board;
        last_board = bus.board;
        n_valid++;
        if (hold_cycles > 0) begin
            hb = bus.board;
            hc = 32'(bus.count);
            unstable = 0;
            for (int i = 0; i < hold_cycles; i++) begin
                bus.start = (i == 10);
                tick();
                if (bus.board !== hb || 32'(bus.count) !== hc || bus.valid !== 1'b1) unstable++;
            end
            bus.start = 1'b0;
            check("hold_stable", unstable, 32'd0);
        end
        bus.next  = 1'b1;
        bus.start = start_with_next;
        tick();
        bus.next  = 1'b0;
        bus.start = 1'b0;
        check("ack_valid_low", 32'(bus.valid), 32'd0);
        check("ack_busy", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        bit gv, gd;
        bus.start = 1'b0;
        bus.next  = 1'b0;
        reset     = 1'b1;

        build_model();
        check("model_size", model_sols.size(), 32'd92);

        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_board", 32'(bus.board), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        reset = 1'b0;
        tick();

        // next outside SOLUTION is ignored
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        check("idle_next_busy", 32'(bus.busy), 32'd0);
        check("idle_next_valid", 32'(bus.valid), 32'd0);

        sb_push(92);
        pulse_start();
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_count", 32'(bus.count), 32'd0);

        for (int s = 0; s < 200; s++) begin
            wait_event(gv, gd, 1'b1);
            if (!gv) break;
            handle_solution((s == 0) ? 50 : 0, s == 1);
        end
        check("first_board", 32'(first_board), 32'(pack_cols(0, 4, 7, 5, 2, 6, 1, 3)));
        check("last_board", 32'(last_board), 32'(pack_cols(7, 3, 0, 2, 5, 1, 6, 4)));
        check("n_valid", n_valid, 32'd92);
        check("sb_drained", sb_q.size(), 32'd0);
        check("end_done", 32'(bus.done), 32'd1);
        check("end_busy", 32'(bus.busy), 32'd0);
        check("end_valid", 32'(bus.valid), 32'd0);
        check("end_count", 32'(bus.count), 32'd92);

        bus.next = 1'b1;
        repeat (3) tick();
        bus.next = 1'b0;
        check("done_hold", 32'(bus.done), 32'd1);
        check("done_count_hold", 32'(bus.count), 32'd92);

        // Restart from DONE
        pulse_start();
        check("restart_busy", 32'(bus.busy), 32'd1);
        check("restart_done", 32'(bus.done), 32'd0);
        check("restart_count", 32'(bus.count), 32'd0);
        check("restart_board", 32'(bus.board), 32'd0);

        sb_push(3);
        for (int s = 0; s < 3; s++) begin
            wait_event(gv, gd, 1'b0);
            check("restart_sol", 32'(gv), 32'd1);
            if (!gv) break;
            handle_solution(0, 1'b0);
        end
        repeat (2) tick();
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_valid", 32'(bus.valid), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_board", 32'(bus.board), 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        sb_q.delete();
        tick();
        check("idle_stays", 32'(bus.busy), 32'd0);

        sb_push(1);
        pulse_start();
        wait_event(gv, gd, 1'b0);
        check("after_rst_sol", 32'(gv), 32'd1);
        if (gv) handle_solution(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/queen_solver.md
QUEEN_SOLVER -- requirements
Module: queen_solver

Interface
REQ-001 Parameter: CNT_W, default 7, width of the solution counter (must hold 92).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on posedge clk only.
REQ-004 start  input  1  one-cycle pulse that begins a full search; honoured only in IDLE or DONE.
REQ-005 next  input  1  consumer acknowledge of the presented solution; honoured only in SOLUTION.
REQ-006 busy  output  1  high in TRY and BACK states.
REQ-007 valid  output  1  high only in SOLUTION state; board holds a legal 8-queen placement.
REQ-008 done  output  1  high only in DONE state; search space exhausted.
REQ-009 board  output  24  column of queen in row r at bits [3r+2:3r], r=0..7; always driven from internal column registers.
REQ-010 count  output  CNT_W  number of solutions found since last start.

Function
REQ-011 Internal state: row index r (3 bits), candidate column c (3 bits), eight 3-bit column registers col[0..7], FSM {IDLE, TRY, BACK, SOLUTION, DONE}.
REQ-012 Candidate (r,c) is safe iff, for every k<r: col[k]!=c and |col[k]-c| != r-k; evaluated combinationally in the same cycle.
REQ-013 IDLE/DONE + start: col[*]<=0, r<=0, c<=0, count<=0, next state TRY.
REQ-014 TRY, safe, r<7: col[r]<=c, r<=r+1, c<=0, stay TRY.
REQ-015 TRY, safe, r==7: col[7]<=c, count<=count+1, next state SOLUTION.
REQ-016 TRY, unsafe, c<7: c<=c+1, stay TRY.
REQ-017 TRY, unsafe, c==7: if r==0 go DONE, else r<=r-1 and go BACK.
REQ-018 BACK at row r: if col[r]<7, c<=col[r]+1 and go TRY (row r unchanged); if col[r]==7, go DONE when r==0, else r<=r-1 and stay BACK.
REQ-019 SOLUTION: board, count stable; on next, r stays 7 and state goes BACK (search resumes after current placement); without next, hold indefinitely.
REQ-020 One candidate test or one backtrack step per cycle; no multi-cycle operations.
REQ-021 Search order strictly lexicographic: row 0 first, columns ascending; solutions emitted in lexicographic order of board.
REQ-022 start while busy or in SOLUTION is ignored; next outside SOLUTION is ignored; start and next together in SOLUTION: next wins.
REQ-023 count does not wrap in normal use (max 92 < 2^CNT_W); count held in DONE until next start.
REQ-024 busy, valid, done mutually exclusive; all three low in IDLE.

Reset
REQ-025 reset has priority over start/next in every state, including mid-search and SOLUTION.
REQ-026 After reset: state IDLE, r=0, c=0, col[*]=0 (board=0), count=0, busy=valid=done=0.
REQ-027 First rising edge with reset low and start high after reset begins a search normally.

Verification
REQ-028 reset, start pulse -> busy=1 next cycle; first valid shows columns rows0..7 = 0,4,7,5,2,6,1,3, count=1.
REQ-029 Pulse next on every valid -> exactly 92 valid episodes, last board 7,3,0,2,5,1,6,4, then done=1, count=92, busy=0.
REQ-030 Hold next low for 50 cycles in SOLUTION -> board, count, valid unchanged; search resumes only on next.
REQ-031 Assert reset after 3rd solution while busy -> following cycle IDLE, board=0, count=0; new start reproduces solution 1.
REQ-032 start pulses while busy and in SOLUTION -> no effect on board/count sequence; start in DONE restarts, count cleared to 0.
REQ-033 Scoreboard every valid board against software-model list of 92 solutions in order; any illegal board or out-of-order emission fails.
